fir_feeder: RTL and testbench

Upstream driver for the FIR filter's input interface. It accepts coefficients and samples over one valid/ready byte port, stages coefficients in a register file and buffers samples in a small FIFO. It then plays them out on the filter's x_n / s_set_coeffs / s_axis_fir_tvalid signals in the sequence the filter's control FSM expects. It sits between the chip input pins and the FIR instance.

---
 rtl/fir_feeder.sv | 161 ++++++++++++++++
 tb/tb_fir_feeder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_feeder.sv
// Upstream driver for the FIR input: stages coefficients, buffers samples in a FIFO
// and replays them on x_n / s_set_coeffs / s_axis_fir_tvalid in the filter's expected order.
module fir_feeder #(
    parameter int unsigned TAP_SIZE    = 6,
    parameter int unsigned NBR_OF_TAPS = 5,
    parameter int unsigned X_N_SIZE    = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [X_N_SIZE-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_is_coeff,
    output logic                in_ready,
    output logic [X_N_SIZE-1:0] x_n,
    output logic                s_set_coeffs,
    output logic                s_axis_fir_tvalid,
    output logic                busy,
    output logic [2:0]          coeff_cnt
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, GAP, STREAM} state_t;

    state_t               state_q, state_d;
    logic [2:0]           coeff_cnt_q, coeff_cnt_d;
    logic [2:0]           load_left_q, load_left_d;
    logic [TAP_SIZE-1:0]  stage_q [NBR_OF_TAPS];
    logic [TAP_SIZE-1:0]  stage_d [NBR_OF_TAPS];
    logic [X_N_SIZE-1:0]  mem_q [FIFO_DEPTH];
    logic [X_N_SIZE-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     occ_q, occ_d;
    logic [X_N_SIZE-1:0]  x_n_q, x_n_d;
    logic                 set_q, set_d, tvalid_q, tvalid_d;

    logic fifo_full, fifo_empty, load_pending, coeff_ready;
    logic coeff_we, push, pop, clr_cnt;

    assign fifo_full    = (occ_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty   = (occ_q == '0);
    assign load_pending = (coeff_cnt_q == 3'(NBR_OF_TAPS));
    assign coeff_ready  = !load_pending && (state_q != LOAD);
    assign in_ready     = in_is_coeff ? coeff_ready : !fifo_full;
    assign coeff_we     = in_valid && in_is_coeff && coeff_ready;
    assign push         = in_valid && !in_is_coeff && !fifo_full;

    // Sequencer: LOAD presents staging from the top index down so staging[0] ends in tap 0.
    always_comb begin
        state_d     = state_q;
        load_left_d = load_left_q;
        x_n_d       = '0;
        set_d       = 1'b0;
        tvalid_d    = 1'b0;
        pop         = 1'b0;
        clr_cnt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_pending) begin
                    state_d     = LOAD;
                    set_d       = 1'b1;
                    x_n_d       = X_N_SIZE'($signed(stage_q[NBR_OF_TAPS-1]));
                    load_left_d = 3'(NBR_OF_TAPS - 1);
                end else if (!fifo_empty) begin
                    state_d  = STREAM;
                    pop      = 1'b1;
                    tvalid_d = 1'b1;
                    x_n_d    = mem_q[rd_ptr_q];
                end
            end
            LOAD: begin
                if (load_left_q != 3'd0) begin
                    set_d       = 1'b1;
                    x_n_d       = X_N_SIZE'($signed(stage_q[load_left_q - 3'd1]));
                    load_left_d = load_left_q - 3'd1;
                end else begin
                    state_d = GAP;
                    clr_cnt = 1'b1;
                end
            end
            GAP: state_d = IDLE;
            STREAM: begin
                if (load_pending) begin
                    state_d = GAP;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    tvalid_d = 1'b1;
                    x_n_d    = mem_q[rd_ptr_q];
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Coefficient staging and sample FIFO bookkeeping.
    always_comb begin
        coeff_cnt_d = coeff_cnt_q;
        stage_d     = stage_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        if (clr_cnt) begin
            coeff_cnt_d = 3'd0;
        end else if (coeff_we) begin
            stage_d[coeff_cnt_q] = in_data[TAP_SIZE-1:0];
            coeff_cnt_d          = coeff_cnt_q + 3'd1;
        end
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            coeff_cnt_q <= 3'd0;
            load_left_q <= 3'd0;
            stage_q     <= '{default: '0};
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            x_n_q       <= '0;
            set_q       <= 1'b0;
            tvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            coeff_cnt_q <= coeff_cnt_d;
            load_left_q <= load_left_d;
            stage_q     <= stage_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            x_n_q       <= x_n_d;
            set_q       <= set_d;
            tvalid_q    <= tvalid_d;
        end
    end

    assign x_n               = x_n_q;
    assign s_set_coeffs      = set_q;
    assign s_axis_fir_tvalid = tvalid_q;
    assign busy              = (state_q != IDLE);
    assign coeff_cnt         = coeff_cnt_q;

endmodule

// File: tb/tb_fir_feeder.sv
// Bench for fir_feeder: directed scenarios plus random traffic, checked against
// an output-schedule model built from queues.
module tb_fir_feeder;

    localparam int TAP   = 6;
    localparam int NT    = 5;
    localparam int XW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [XW-1:0] in_data;
    logic          in_valid;
    logic          in_is_coeff;
    logic          in_ready;
    logic [XW-1:0] x_n;
    logic          s_set_coeffs;
    logic          s_axis_fir_tvalid;
    logic          busy;
    logic [2:0]    coeff_cnt;

    fir_feeder #(.TAP_SIZE(TAP), .NBR_OF_TAPS(NT), .X_N_SIZE(XW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_is_coeff(in_is_coeff), .in_ready(in_ready), .x_n(x_n),
        .s_set_coeffs(s_set_coeffs), .s_axis_fir_tvalid(s_axis_fir_tvalid),
        .busy(busy), .coeff_cnt(coeff_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Each entry is what the filter port shows for one cycle.
    typedef enum {K_IDLE, K_GAP, K_COEF, K_SAMP} kind_t;
    typedef struct {
        kind_t         k;
        logic          clr;
        logic [XW-1:0] x;
    } ent_t;

    ent_t           cur;
    ent_t           sched[$];
    logic [XW-1:0]  fifo_m[$];
    logic [TAP-1:0] stg[$];
    logic [XW-1:0]  obs_c[$];
    logic [XW-1:0]  obs_s[$];

    function automatic ent_t mk(kind_t k, logic clr, logic [XW-1:0] x);
        ent_t e;
        e.k = k; e.clr = clr; e.x = x;
        return e;
    endfunction

    function automatic logic [XW-1:0] sx(logic [TAP-1:0] c);
        int v = int'(c);
        if (v >= 2 ** (TAP - 1)) v = v - 2 ** TAP;
        return XW'(v);
    endfunction

    function automatic logic exp_ready(logic c);
        if (c) return (stg.size() < NT) && (cur.k != K_COEF);
        return fifo_m.size() < DEPTH;
    endfunction

    task automatic model_reset();
        cur = mk(K_IDLE, 1'b0, '0);
        sched.delete();
        fifo_m.delete();
        stg.delete();
    endtask

    task automatic model_edge(logic v, logic c, logic [XW-1:0] d);
        logic acc = v && exp_ready(c);
        logic pending = (stg.size() == NT);
        if (sched.size() > 0) begin
            cur = sched.pop_front();
            if (cur.k == K_GAP && cur.clr) stg.delete();
        end else if (cur.k == K_SAMP && pending) begin
            cur = mk(K_GAP, 1'b0, '0);
            sched.push_back(mk(K_IDLE, 1'b0, '0));
        end else if (cur.k != K_SAMP && pending) begin
            for (int i = NT - 1; i >= 0; i--) sched.push_back(mk(K_COEF, 1'b0, sx(stg[i])));
            sched.push_back(mk(K_GAP, 1'b1, '0));
            sched.push_back(mk(K_IDLE, 1'b0, '0));
            cur = sched.pop_front();
        end else if (fifo_m.size() > 0) begin
            cur = mk(K_SAMP, 1'b0, fifo_m.pop_front());
        end else begin
            cur = mk(K_IDLE, 1'b0, '0);
        end
        if (acc) begin
            if (c) stg.push_back(d[TAP-1:0]);
            else   fifo_m.push_back(d);
        end
    endtask

    task automatic check(string tag, logic [XW-1:0] obs, logic [XW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        check("x_n", x_n, (cur.k == K_COEF || cur.k == K_SAMP) ? cur.x : '0);
        check("s_set_coeffs", XW'(s_set_coeffs), XW'(cur.k == K_COEF));
        check("tvalid", XW'(s_axis_fir_tvalid), XW'(cur.k == K_SAMP));
        check("busy", XW'(busy), XW'(cur.k != K_IDLE));
        check("coeff_cnt", XW'(coeff_cnt), XW'(stg.size()));
    endtask

    // One clock: drive at negedge, check in_ready, advance model at the edge, check outputs.
    task automatic step(logic v, logic c, logic [XW-1:0] d);
        in_valid = v; in_is_coeff = c; in_data = d;
        #1;
        check("in_ready", XW'(in_ready), XW'(exp_ready(c)));
        @(posedge clk);
        model_edge(v, c, d);
        @(negedge clk);
        if (s_set_coeffs) obs_c.push_back(x_n);
        if (s_axis_fir_tvalid) obs_s.push_back(x_n);
        check_outputs();
    endtask

    task automatic send(logic c, logic [XW-1:0] d);
        int n = 0;
        forever begin
            logic acc = exp_ready(c);
            step(1'b1, c, d);
            if (acc) break;
            n++;
            if (n > 40) begin
                check("send_timeout", 8'd1, 8'd0);
                break;
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'($urandom), XW'($urandom));
    endtask

    task automatic cmp_seq(string tag, logic [XW-1:0] got[$], logic [XW-1:0] want[$]);
        check({tag, "_len"}, XW'(got.size()), XW'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++) check(tag, got[i], want[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) begin
            in_valid = 1'($urandom); in_is_coeff = 1'($urandom); in_data = XW'($urandom);
            @(negedge clk);
        end
        reset = 1'b0;
        model_reset();
        in_valid = 1'b0;
    endtask

    logic [XW-1:0] want[$];
    logic [XW-1:0] pushed[$];

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_is_coeff = 1'b0; in_data = '0;
        model_reset();
        @(negedge clk);

        // 1: reset with random inputs, then idle
        do_reset();
        #1;
        check_outputs();
        in_is_coeff = 1'b1; #1; check("rdy_coeff_after_reset", XW'(in_ready), 8'd1);
        in_is_coeff = 1'b0; #1; check("rdy_samp_after_reset", XW'(in_ready), 8'd1);
        @(negedge clk);

        // 2: coefficient load with sign extension and reversed order
        obs_c.delete();
        send(1'b1, 8'h01); send(1'b1, 8'h02); send(1'b1, 8'h3F);
        send(1'b1, 8'h20); send(1'b1, 8'h05);
        idle(9);
        want = '{8'h05, 8'hE0, 8'hFF, 8'h02, 8'h01};
        cmp_seq("load_seq", obs_c, want);
        check("cnt_after_load", XW'(coeff_cnt), 8'd0);

        // 3: back-to-back samples
        obs_s.delete();
        send(1'b0, 8'h10); send(1'b0, 8'h20); send(1'b0, 8'h30);
        idle(4);
        want = '{8'h10, 8'h20, 8'h30};
        cmp_seq("stream_seq", obs_s, want);
        check("busy_after_stream", XW'(busy), 8'd0);

        // 4: fill the FIFO while a load occupies the FSM
        obs_s.delete(); pushed.delete();
        for (int i = 0; i < NT; i++) send(1'b1, XW'($urandom));
        for (int i = 0; i < 5; i++) begin
            logic [XW-1:0] s = XW'($urandom);
            pushed.push_back(s);
            send(1'b0, s);
        end
        idle(12);
        cmp_seq("full_order", obs_s, pushed);

        // 5: load becomes pending after two samples have been streamed
        obs_s.delete(); obs_c.delete();
        for (int i = 0; i < NT - 1; i++) send(1'b1, XW'(8'h11 + i));
        send(1'b0, 8'hA1); send(1'b0, 8'hA2);
        send(1'b1, 8'h15);
        send(1'b0, 8'hA3); send(1'b0, 8'hA4);
        idle(16);
        want = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        cmp_seq("pend_samples", obs_s, want);
        want = '{8'h15, 8'h14, 8'h13, 8'h12, 8'h11};
        cmp_seq("pend_coeffs", obs_c, want);

        // 6: asynchronous reset in the third LOAD cycle
        for (int i = 0; i < NT; i++) send(1'b1, XW'($urandom));
        step(1'b1, 1'b0, 8'hAA);
        idle(2);
        check("in_load_before_reset", XW'(s_set_coeffs), 8'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_x_n", x_n, 8'd0);
        check("async_set", XW'(s_set_coeffs), 8'd0);
        check("async_busy", XW'(busy), 8'd0);
        check("async_cnt", XW'(coeff_cnt), 8'd0);
        @(negedge clk);
        do_reset();
        obs_s.delete(); obs_c.delete();
        idle(10);
        check("no_resume_coeffs", XW'(obs_c.size()), 8'd0);
        check("fifo_emptied", XW'(obs_s.size()), 8'd0);

        // random traffic against the model, with one reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step(($urandom % 3) != 0, ($urandom % 4) == 0, XW'($urandom));
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
